// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: hazard-unit stalls, predictor/execute redirects going in,
// fetch PC and F/D pipeline state coming out.
interface fetch_pc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int COUNT_W    = 16
);
    // Control and redirect inputs to the fetch unit
    logic                  StallF;
    logic                  StallD;
    logic [DATA_WIDTH-1:0] PCBPU;
    logic                  PCBPUSrc;
    logic                  flushBranch;
    logic                  JumpE;
    logic [DATA_WIDTH-1:0] PCTargetE;

    // Fetch and decode-stage state produced by the fetch unit
    logic [DATA_WIDTH-1:0] PCF;
    logic [DATA_WIDTH-1:0] PCPlus4F;
    logic [DATA_WIDTH-1:0] PCD;
    logic [DATA_WIDTH-1:0] PCPlus4D;
    logic                  PredTakenD;
    logic                  ValidD;
    logic                  FlushE;
    logic [COUNT_W-1:0]    RedirectCount;

    // Core side: hazard unit, predictor and execute stage
    modport master (
        output StallF, StallD, PCBPU, PCBPUSrc, flushBranch, JumpE, PCTargetE,
        input  PCF, PCPlus4F, PCD, PCPlus4D, PredTakenD, ValidD, FlushE, RedirectCount
    );

    // Fetch unit side
    modport slave (
        input  StallF, StallD, PCBPU, PCBPUSrc, flushBranch, JumpE, PCTargetE,
        output PCF, PCPlus4F, PCD, PCPlus4D, PredTakenD, ValidD, FlushE, RedirectCount
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register, next-PC selection and F/D pipeline register.
// A redirect (predictor mispredict or execute-stage jump) wins over stalls and
// bubbles the decode slot; mispredicts are tallied in a saturating counter.
module fetch_pc_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    COUNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    fetch_pc_if.slave  bus
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_REDIRECT
    } state_t;

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] RESET_ALGN = {RESET_PC[DATA_WIDTH-1:2], 2'b00};
    localparam logic [COUNT_W-1:0]    COUNT_MAX  = '1;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_pcf;
    logic [DATA_WIDTH-1:0] w_pcf_next;
    logic [DATA_WIDTH-1:0] w_pcplus4f;
    logic [DATA_WIDTH-1:0] r_pcd;
    logic [DATA_WIDTH-1:0] r_pcplus4d;
    logic                  r_pred_taken_d;
    logic                  r_valid_d;
    logic [COUNT_W-1:0]    r_redirect_count;
    logic                  w_redirect;

    // Any redirect source kills younger work; mispredict takes priority for the target.
    assign w_redirect = bus.flushBranch | bus.JumpE;
    // Modulo-2^DATA_WIDTH increment: the top aligned address wraps to zero.
    assign w_pcplus4f = r_pcf + PC_STEP;

    // FSM state register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_BOOT;
        else     r_state <= w_state_next;
    end

    // FSM next state: BOOT lasts one cycle, REDIRECT marks the cycle after a redirect
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT:               w_state_next = S_RUN;
            S_RUN, S_REDIRECT:    w_state_next = w_redirect ? S_REDIRECT : S_RUN;
            default:              w_state_next = S_BOOT;
        endcase
    end

    // Next-PC select: mispredict, jump, stall, predicted-taken, sequential
    always_comb begin
        w_pcf_next = r_pcf;
        if (r_state != S_BOOT) begin
            if (bus.flushBranch)   w_pcf_next = {bus.PCBPU[DATA_WIDTH-1:2], 2'b00};
            else if (bus.JumpE)    w_pcf_next = {bus.PCTargetE[DATA_WIDTH-1:2], 2'b00};
            else if (bus.StallF)   w_pcf_next = r_pcf;
            else if (bus.PCBPUSrc) w_pcf_next = {bus.PCBPU[DATA_WIDTH-1:2], 2'b00};
            else                   w_pcf_next = w_pcplus4f;
        end
    end

    // Fetch PC register
    always_ff @(posedge clk) begin
        if (rst) r_pcf <= RESET_ALGN;
        else     r_pcf <= w_pcf_next;
    end

    // F/D pipeline register: redirect bubbles, stall holds, otherwise load from fetch
    always_ff @(posedge clk) begin
        if (rst || w_redirect) begin
            r_pcd          <= '0;
            r_pcplus4d     <= '0;
            r_pred_taken_d <= 1'b0;
            r_valid_d      <= 1'b0;
        end else if (!bus.StallD && r_state != S_BOOT) begin
            r_pcd          <= r_pcf;
            r_pcplus4d     <= w_pcplus4f;
            r_pred_taken_d <= bus.PCBPUSrc;
            r_valid_d      <= 1'b1;
        end
    end

    // Saturating mispredict counter; execute-stage jumps are not mispredicts
    always_ff @(posedge clk) begin
        if (rst)
            r_redirect_count <= '0;
        else if (bus.flushBranch && r_redirect_count != COUNT_MAX)
            r_redirect_count <= r_redirect_count + COUNT_W'(1);
    end

    assign bus.PCF           = r_pcf;
    assign bus.PCPlus4F      = w_pcplus4f;
    assign bus.PCD           = r_pcd;
    assign bus.PCPlus4D      = r_pcplus4d;
    assign bus.PredTakenD    = r_pred_taken_d;
    assign bus.ValidD        = r_valid_d;
    assign bus.FlushE        = w_redirect;
    assign bus.RedirectCount = r_redirect_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a main instance (RESET_PC=0x100, 16-bit counter)
// and a second instance with a 2-bit counter for the saturation case.
module tb_fetch_pc_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    fetch_pc_if #(.DATA_WIDTH(32), .COUNT_W(16)) a_if ();
    fetch_pc_if #(.DATA_WIDTH(32), .COUNT_W(2))  b_if ();

    fetch_pc_unit #(.DATA_WIDTH(32), .RESET_PC(32'h100), .COUNT_W(16)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    fetch_pc_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0), .COUNT_W(2)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later, away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_if.StallF = 0; a_if.StallD = 0; a_if.PCBPU = '0; a_if.PCBPUSrc = 0;
        a_if.flushBranch = 0; a_if.JumpE = 0; a_if.PCTargetE = '0;
        b_if.StallF = 0; b_if.StallD = 0; b_if.PCBPU = '0; b_if.PCBPUSrc = 0;
        b_if.flushBranch = 0; b_if.JumpE = 0; b_if.PCTargetE = '0;

        // Reset state
        tick();
        chk("rst_pcf",      a_if.PCF, 32'h100);
        chk("rst_pcplus4f", a_if.PCPlus4F, 32'h104);
        chk("rst_pcd",      a_if.PCD, 32'h0);
        chk("rst_pcplus4d", a_if.PCPlus4D, 32'h0);
        chk("rst_valid",    32'(a_if.ValidD), 32'h0);
        chk("rst_pred",     32'(a_if.PredTakenD), 32'h0);
        chk("rst_count",    32'(a_if.RedirectCount), 32'h0);
        chk("rst_count_b",  32'(b_if.RedirectCount), 32'h0);

        // Boot: PC holds once, then sequential fetch
        rst = 0;
        tick();
        chk("boot_pcf",   a_if.PCF, 32'h100);
        chk("boot_valid", 32'(a_if.ValidD), 32'h0);
        tick();
        chk("seq1_pcf",    a_if.PCF, 32'h104);
        chk("seq1_pcd",    a_if.PCD, 32'h100);
        chk("seq1_p4d",    a_if.PCPlus4D, 32'h104);
        chk("seq1_valid",  32'(a_if.ValidD), 32'h1);
        chk("seq1_pred",   32'(a_if.PredTakenD), 32'h0);
        tick();
        chk("seq2_pcf",    a_if.PCF, 32'h108);
        chk("seq2_pcd",    a_if.PCD, 32'h104);

        // Predicted taken
        a_if.PCBPUSrc = 1; a_if.PCBPU = 32'h200;
        tick();
        chk("bpu_pcf",   a_if.PCF, 32'h200);
        chk("bpu_pcd",   a_if.PCD, 32'h108);
        chk("bpu_pred",  32'(a_if.PredTakenD), 32'h1);
        chk("bpu_valid", 32'(a_if.ValidD), 32'h1);
        a_if.PCBPUSrc = 0;

        // Mispredict overrides both stalls
        a_if.StallF = 1; a_if.StallD = 1; a_if.flushBranch = 1; a_if.PCBPU = 32'h10C;
        #1;
        chk("flush_flushe", 32'(a_if.FlushE), 32'h1);
        tick();
        chk("flush_pcf",   a_if.PCF, 32'h10C);
        chk("flush_valid", 32'(a_if.ValidD), 32'h0);
        chk("flush_pcd",   a_if.PCD, 32'h0);
        chk("flush_pred",  32'(a_if.PredTakenD), 32'h0);
        chk("flush_count", 32'(a_if.RedirectCount), 32'h1);
        a_if.flushBranch = 0;
        #1;
        chk("idle_flushe", 32'(a_if.FlushE), 32'h0);
        tick();
        chk("stall_pcf",   a_if.PCF, 32'h10C);
        chk("stall_valid", 32'(a_if.ValidD), 32'h0);
        a_if.StallF = 0; a_if.StallD = 0;
        tick();
        chk("resume_pcf",   a_if.PCF, 32'h110);
        chk("resume_pcd",   a_if.PCD, 32'h10C);
        chk("resume_valid", 32'(a_if.ValidD), 32'h1);

        // Mispredict beats jump; jump target low bits dropped; jump not counted
        a_if.flushBranch = 1; a_if.PCBPU = 32'h300; a_if.JumpE = 1; a_if.PCTargetE = 32'h400;
        tick();
        chk("both_pcf",   a_if.PCF, 32'h300);
        chk("both_count", 32'(a_if.RedirectCount), 32'h2);
        chk("both_valid", 32'(a_if.ValidD), 32'h0);
        a_if.flushBranch = 0; a_if.PCTargetE = 32'h403;
        tick();
        chk("jump_pcf",   a_if.PCF, 32'h400);
        chk("jump_count", 32'(a_if.RedirectCount), 32'h2);
        chk("jump_valid", 32'(a_if.ValidD), 32'h0);
        a_if.JumpE = 0;
        tick();
        chk("post_jump_pcf",   a_if.PCF, 32'h404);
        chk("post_jump_pcd",   a_if.PCD, 32'h400);
        chk("post_jump_valid", 32'(a_if.ValidD), 32'h1);

        // Predictor target low bits dropped
        a_if.PCBPUSrc = 1; a_if.PCBPU = 32'h503;
        tick();
        chk("align_pcf", a_if.PCF, 32'h500);
        chk("align_pcd", a_if.PCD, 32'h404);

        // Wrap at the top of the address space
        a_if.PCBPU = 32'hFFFF_FFFC;
        tick();
        chk("top_pcf",     a_if.PCF, 32'hFFFF_FFFC);
        chk("top_pcplus4", a_if.PCPlus4F, 32'h0);
        chk("top_pred",    32'(a_if.PredTakenD), 32'h1);
        a_if.PCBPUSrc = 0;
        tick();
        chk("wrap_pcf",  a_if.PCF, 32'h0);
        chk("wrap_pcd",  a_if.PCD, 32'hFFFF_FFFC);
        chk("wrap_p4d",  a_if.PCPlus4D, 32'h0);
        chk("wrap_pred", 32'(a_if.PredTakenD), 32'h0);

        // Mid-stream reset overrides a pending taken prediction
        a_if.PCBPUSrc = 1; a_if.PCBPU = 32'h700; rst = 1;
        tick();
        chk("mrst_pcf",   a_if.PCF, 32'h100);
        chk("mrst_pcd",   a_if.PCD, 32'h0);
        chk("mrst_p4d",   a_if.PCPlus4D, 32'h0);
        chk("mrst_valid", 32'(a_if.ValidD), 32'h0);
        chk("mrst_pred",  32'(a_if.PredTakenD), 32'h0);
        chk("mrst_count", 32'(a_if.RedirectCount), 32'h0);
        rst = 0; a_if.PCBPUSrc = 0;
        tick();
        chk("mrst_boot_pcf",   a_if.PCF, 32'h100);
        chk("mrst_boot_valid", 32'(a_if.ValidD), 32'h0);

        // 2-bit counter saturates at 3
        b_if.flushBranch = 1; b_if.PCBPU = 32'h40;
        tick();
        chk("sat_pcf", b_if.PCF, 32'h40);
        chk("sat_c1",  32'(b_if.RedirectCount), 32'h1);
        tick();
        chk("sat_c2",  32'(b_if.RedirectCount), 32'h2);
        tick();
        chk("sat_c3",  32'(b_if.RedirectCount), 32'h3);
        tick();
        chk("sat_c4",  32'(b_if.RedirectCount), 32'h3);
        tick();
        chk("sat_c5",  32'(b_if.RedirectCount), 32'h3);
        chk("sat_valid", 32'(b_if.ValidD), 32'h0);
        b_if.flushBranch = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
